// File: rtl/btb_pkg.sv
// Shared constants, counter helpers and sweep-state type for the branch target buffer.
package btb_pkg;

  localparam logic [1:0] BT_COND     = 2'b00;
  localparam logic [1:0] BT_JUMP     = 2'b10;
  localparam logic [1:0] CNTR_WEAK_T = 2'b10;

  typedef enum logic {
    StClear,
    StIdle
  } btb_state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_way_array.sv
// One BTB way: valid/tag/target/type/counter storage with a combinational update-side
// read, a registered lookup read, one write port and a per-set valid clear.
module btb_way_array #(
  parameter int unsigned ENTRIES = 64,
  localparam int unsigned IDX_W = $clog2(ENTRIES),
  localparam int unsigned TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  // combinational read for update hit detection
  input  logic [IDX_W-1:0] upd_idx,
  output logic             upd_valid,
  output logic [TAG_W-1:0] upd_tag,
  output logic [1:0]       upd_type,
  // registered read for lookup
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [29:0]      rd_target,
  output logic [1:0]       rd_type,
  output logic [1:0]       rd_cntr,
  // write port: wr_en writes a whole entry, cntr_en only the counter
  input  logic             wr_en,
  input  logic             cntr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [29:0]      wr_target,
  input  logic [1:0]       wr_type,
  input  logic [1:0]       wr_cntr,
  // valid clear
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [29:0]        target_q [ENTRIES];
  logic [1:0]         type_q   [ENTRIES];
  logic [1:0]         cntr_q   [ENTRIES];

  logic             rd_valid_q;
  logic [TAG_W-1:0] rd_tag_q;
  logic [29:0]      rd_target_q;
  logic [1:0]       rd_type_q;
  logic [1:0]       rd_cntr_q;

  // Valid bits need no reset: the sweep clears them before any lookup can hit.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      type_q[wr_idx]   <= wr_type;
    end
    if (wr_en || cntr_en) begin
      cntr_q[wr_idx] <= wr_cntr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q  <= 1'b0;
      rd_tag_q    <= '0;
      rd_target_q <= '0;
      rd_type_q   <= '0;
      rd_cntr_q   <= '0;
    end else if (rd_en) begin
      rd_valid_q  <= valid_q[rd_idx];
      rd_tag_q    <= tag_q[rd_idx];
      rd_target_q <= target_q[rd_idx];
      rd_type_q   <= type_q[rd_idx];
      rd_cntr_q   <= cntr_q[rd_idx];
    end
  end

  assign upd_valid = valid_q[upd_idx];
  assign upd_tag   = tag_q[upd_idx];
  assign upd_type  = type_q[upd_idx];

  assign rd_valid  = rd_valid_q;
  assign rd_tag    = rd_tag_q;
  assign rd_target = rd_target_q;
  assign rd_type   = rd_type_q;
  assign rd_cntr   = rd_cntr_q;

endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative BTB with bimodal counters, per-set LRU and a valid-clear sweep FSM.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        invalidate_i,
  output logic        busy_o,
  input  logic        lkp_valid_i,
  input  logic [29:0] lkp_pc_i,
  output logic        lkp_rsp_valid_o,
  output logic        btb_vld_o,
  output logic [29:0] btb_target_o,
  output logic [1:0]  btb_type_o,
  output logic [1:0]  bm_pred_o,
  output logic        btb_way_o,
  input  logic        c1_res_valid_i,
  input  logic        c1_excp_i,
  input  logic [29:0] c1_btb_vpc_i,
  input  logic [31:0] c1_btb_target_i,
  input  logic [1:0]  c1_cntr_pred_i,
  input  logic        c1_bnch_present_i,
  input  logic [1:0]  c1_bnch_type_i,
  input  logic        c1_btb_way_i,
  input  logic        c1_btb_bm_mod_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sweep;

  logic [ENTRIES-1:0] lru_q;

  logic             rsp_valid_q;
  logic [TAG_W-1:0] lkp_tag_q;
  logic             lkp_live_q;
  logic             lru_snap_q;

  logic [IDX_W-1:0] lkp_set;
  logic [TAG_W-1:0] lkp_tag;
  logic [IDX_W-1:0] upd_set;
  logic [TAG_W-1:0] upd_tag;

  logic             upd_valid_w [2];
  logic [TAG_W-1:0] upd_tag_w   [2];
  logic [1:0]       upd_type_w  [2];
  logic             rd_valid_w  [2];
  logic [TAG_W-1:0] rd_tag_w    [2];
  logic [29:0]      rd_target_w [2];
  logic [1:0]       rd_type_w   [2];
  logic [1:0]       rd_cntr_w   [2];
  logic [1:0]       lkp_hit;

  logic             upd_go;
  logic             upd_hit;
  logic             wr_all, wr_cntr, inval;
  logic             lru_we, lru_val;
  logic [1:0]       new_cntr;
  logic [IDX_W-1:0] clr_idx;
  logic             unused_tgt_lsb;

  assign lkp_set        = lkp_pc_i[IDX_W-1:0];
  assign lkp_tag        = lkp_pc_i[29:IDX_W];
  assign upd_set        = c1_btb_vpc_i[IDX_W-1:0];
  assign upd_tag        = c1_btb_vpc_i[29:IDX_W];
  assign unused_tgt_lsb = ^c1_btb_target_i[1:0];

  // Sweep FSM
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q <= StClear;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sweep   = 1'b0;
    unique case (state_q)
      StClear: begin
        sweep = 1'b1;
        if (idx_q == IDX_W'(ENTRIES - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StIdle: begin
        if (invalidate_i) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
    endcase
  end

  assign busy_o = (state_q == StClear) || cpu_reset_i;

  // Update decode; hit is judged against the way the prediction reported.
  assign upd_go  = c1_res_valid_i && (state_q == StIdle);
  assign upd_hit = upd_valid_w[c1_btb_way_i] && (upd_tag_w[c1_btb_way_i] == upd_tag);

  always_comb begin
    wr_all   = 1'b0;
    wr_cntr  = 1'b0;
    inval    = 1'b0;
    lru_we   = 1'b0;
    lru_val  = 1'b0;
    new_cntr = c1_cntr_pred_i;
    if (upd_go) begin
      if (c1_excp_i && c1_bnch_present_i) begin
        wr_all   = 1'b1;
        new_cntr = upd_hit ? sat_inc(c1_cntr_pred_i) : CNTR_WEAK_T;
        lru_we   = 1'b1;
        lru_val  = !c1_btb_way_i;
      end else if (c1_excp_i) begin
        if (upd_hit) begin
          lru_we = 1'b1;
          if (upd_type_w[c1_btb_way_i] == BT_COND) begin
            wr_cntr  = 1'b1;
            new_cntr = sat_dec(c1_cntr_pred_i);
            lru_val  = !c1_btb_way_i;
          end else begin
            inval   = 1'b1;
            lru_val = c1_btb_way_i;
          end
        end
      end else if (c1_btb_bm_mod_i && upd_hit) begin
        wr_cntr  = 1'b1;
        new_cntr = sat_inc(c1_cntr_pred_i);
        lru_we   = 1'b1;
        lru_val  = !c1_btb_way_i;
      end
    end
  end

  // Sweep and invalidation never coincide: updates only run while idle.
  assign clr_idx = sweep ? idx_q : upd_set;

  for (genvar g = 0; g < 2; g++) begin : g_way
    btb_way_array #(
      .ENTRIES(ENTRIES)
    ) u_way (
      .clk       (cpu_clock_i),
      .rst       (cpu_reset_i),
      .upd_idx   (upd_set),
      .upd_valid (upd_valid_w[g]),
      .upd_tag   (upd_tag_w[g]),
      .upd_type  (upd_type_w[g]),
      .rd_en     (lkp_valid_i),
      .rd_idx    (lkp_set),
      .rd_valid  (rd_valid_w[g]),
      .rd_tag    (rd_tag_w[g]),
      .rd_target (rd_target_w[g]),
      .rd_type   (rd_type_w[g]),
      .rd_cntr   (rd_cntr_w[g]),
      .wr_en     (wr_all && (c1_btb_way_i == 1'(g))),
      .cntr_en   (wr_cntr && (c1_btb_way_i == 1'(g))),
      .wr_idx    (upd_set),
      .wr_tag    (upd_tag),
      .wr_target (c1_btb_target_i[31:2]),
      .wr_type   (c1_bnch_type_i),
      .wr_cntr   (new_cntr),
      .clr_en    (sweep || (inval && (c1_btb_way_i == 1'(g)))),
      .clr_idx   (clr_idx)
    );

    assign lkp_hit[g] = lkp_live_q && rd_valid_w[g] && (rd_tag_w[g] == lkp_tag_q);
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      lru_q <= '0;
    end else if (lru_we) begin
      lru_q[upd_set] <= lru_val;
    end
  end

  // Lookup context captured alongside the registered array read.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      rsp_valid_q <= 1'b0;
      lkp_tag_q   <= '0;
      lkp_live_q  <= 1'b0;
      lru_snap_q  <= 1'b0;
    end else begin
      rsp_valid_q <= lkp_valid_i;
      if (lkp_valid_i) begin
        lkp_tag_q  <= lkp_tag;
        lkp_live_q <= (state_q == StIdle);
        lru_snap_q <= lru_q[lkp_set];
      end
    end
  end

  assign lkp_rsp_valid_o = rsp_valid_q;

  always_comb begin
    btb_vld_o    = 1'b0;
    btb_target_o = '0;
    btb_type_o   = BT_COND;
    bm_pred_o    = '0;
    btb_way_o    = lru_snap_q;
    if (lkp_hit[0]) begin
      btb_vld_o    = 1'b1;
      btb_target_o = rd_target_w[0];
      btb_type_o   = rd_type_w[0];
      bm_pred_o    = rd_cntr_w[0];
      btb_way_o    = 1'b0;
    end else if (lkp_hit[1]) begin
      btb_vld_o    = 1'b1;
      btb_target_o = rd_target_w[1];
      btb_type_o   = rd_type_w[1];
      bm_pred_o    = rd_cntr_w[1];
      btb_way_o    = 1'b1;
    end
  end

endmodule
